imm_gen_stage: RTL and testbench
================================

Name: imm_gen_stage

Overview:
Parametrised, pipelined immediate generator for the decode stage. It covers all RV32I/RV64I immediate formats (I, S, B, U, J), extracts shift amounts, and computes a PC-relative target.
It sits between fetch and execute behind a valid/ready handshake, with a 2-entry skid buffer, flush, and illegal-opcode flagging.

Parameters:
XLEN, 32, datapath width; legal values are 32 or 64.
SHAMT_W, (XLEN==64 ? 6 : 5), shift-amount width for OP-IMM shifts; derived, do not override.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
flush_i  in  1  drop all buffered entries (branch mispredict / trap)
in_valid_i  in  1  upstream instruction valid
in_ready_o  out  1  block can accept this cycle
instr_i  in  32  instruction word
pc_i  in  XLEN  PC of instr_i
out_valid_o  out  1  output entry valid
out_ready_i  in  1  downstream accepts
instr_o  out  32  instruction passed through
pc_o  out  XLEN  PC passed through
imm_o  out  XLEN  decoded immediate
fmt_o  out  3  format code (imm_pkg::fmt_e)
illegal_o  out  1  opcode not recognised
target_o  out  XLEN  pc + imm, wrap-around modulo 2^XLEN

Behaviour:
- Reset (rst_i high, asynchronous):
  - out_valid_o=0; skid entry invalid; in_ready_o=1.
  - instr_o, pc_o, imm_o, target_o, illegal_o = 0; fmt_o=FMT_R.
  - Reset mid-transfer discards all entries and has no side effects.
- Handshake:
  - A transfer occurs on an edge with valid&ready on that port.
  - in_ready_o = !skid_valid (registered, no combinational path from out_ready_i).
  - Latency is 1 cycle: an instruction accepted at edge N appears at out_valid_o after edge N when the output register is empty or draining.
- Skid buffer:
  - Output register plus one skid register.
  - Accepting while the output is stalled (out_valid_o & !out_ready_i) loads the skid register; in_ready_o then drops.
  - When the output drains, the skid moves to the output and in_ready_o rises the following cycle.
  - Order is strictly FIFO. Maximum 2 entries in flight.
- Simultaneous events:
  - Output drain and input accept on the same edge: the new entry goes to output if skid is empty, otherwise skid→output and input→skid.
  - in_ready_o is guaranteed low when skid is full, so no overflow case exists.
- Flush:
  - At the next edge both entries are invalidated, and any input offered that cycle is dropped.
  - flush_i has priority over the handshake.
  - in_ready_o=1 after the flush edge.
- Immediate decode (combinational, registered at the output). Sign bit is always instr[31]; sign-extend to XLEN:
  - I-type: opcodes 0010011, 0000011, 1100111, 1110011 (plus 0011011 when XLEN=64). Immediate is instr[31:20].
  - Shifts, opcode 0010011 with funct3 001/101: imm = zero-extended instr[20+SHAMT_W-1:20]; funct7 bits excluded. fmt=FMT_SH.
  - Shifts under 0011011 (XLEN=64): 5-bit shamt.
  - S-type, 0100011: {instr[31:25], instr[11:7]}.
  - B-type, 1100011: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U-type, 0110111/0010111: {instr[31:12], 12'b0}, sign-extended when XLEN=64.
  - J-type, 1101111: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - R-type, 0110011 (and 0111011 when XLEN=64): imm=0, fmt=FMT_R, legal.
  - Any other opcode, or instr[1:0]!=2'b11: imm=0, fmt=FMT_R, illegal_o=1. The entry still flows through the pipeline.
- target_o = pc + imm, computed for every format; the consumer ignores it where meaningless.

Decomposition:
- Package imm_pkg holds:
  - fmt_e enum, 3 bits: FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J.
  - Opcode localparams: OP_IMM, OP_IMM32, LOAD, JALR, SYSTEM, STORE, BRANCH, LUI, AUIPC, JAL, OP, OP32.
  - Entry struct: instr, pc, imm, fmt, illegal, target.
- Sub-module imm_extract, combinational: instr[31:0] → imm, fmt, illegal, parametrised by XLEN.
- imm_gen_stage contains the target adder, the skid buffer and the flush control.

Test Plan:
- Core format decode, XLEN=32, one instruction each, out_ready_i=1:
  - 0xFFF00093 → imm 0xFFFFFFFF, fmt FMT_I.
  - 0x0020A423 → imm 0x00000008, FMT_S.
  - 0x123450B7 → imm 0x12345000, FMT_U.
  - 0x008000EF → imm 0x00000008, FMT_J.
- Branch target: 0xFE000EE3 with pc 0x00000100 → imm 0xFFFFFFFC, FMT_B, target 0x000000FC, one cycle after acceptance.
- Shifts and illegal opcode:
  - 0x4030D093 → imm 3, FMT_SH (funct7 stripped).
  - 0x00000000 → illegal_o=1, imm 0.
  - XLEN=64: 0x03F09093 → imm 63.
- Backpressure: back-to-back inputs A, B, C with out_ready_i held low 3 cycles → only A and B accepted; in_ready_o=0 after B. On release, A then B emerge on consecutive cycles, then C.
- Flush with skid full: flush_i plus in_valid_i in the same cycle → out_valid_o=0 next cycle, the offered input is lost, in_ready_o=1.
- Asynchronous reset mid-transfer: rst_i asserted between edges with 2 entries held → out_valid_o falls immediately with no clock edge. After release, the first new input appears with 1-cycle latency.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the decode-stage immediate generator.
package imm_pkg;

  // Widest supported datapath; entries are stored at this width and trimmed at the ports.
  localparam int XLEN_MAX = 64;

  typedef enum logic [2:0] {
    FMT_R  = 3'd0,
    FMT_I  = 3'd1,
    FMT_SH = 3'd2,
    FMT_S  = 3'd3,
    FMT_B  = 3'd4,
    FMT_U  = 3'd5,
    FMT_J  = 3'd6
  } fmt_e;

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_IMM32 = 7'b0011011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP32     = 7'b0111011;

  typedef struct packed {
    logic [31:0]         instr;
    logic [XLEN_MAX-1:0] pc;
    logic [XLEN_MAX-1:0] imm;
    fmt_e                fmt;
    logic                illegal;
    logic [XLEN_MAX-1:0] target;
  } entry_t;

  // funct3 values 001 (SLLI) and 101 (SRLI/SRAI) select the shift forms of OP-IMM.
  function automatic logic is_shift(input logic [2:0] funct3);
    return (funct3 == 3'b001) || (funct3 == 3'b101);
  endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: instruction word to immediate, format and illegal flag.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = (XLEN == 64) ? 6 : 5
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  // Decode the opcode and assemble the sign-extended immediate for its format.
  always_comb begin
    imm     = '0;
    fmt     = FMT_R;
    illegal = 1'b0;
    if (instr[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (opcode)
        OP_IMM: begin
          if (is_shift(funct3)) begin
            imm = XLEN'(instr[20 +: SHAMT_W]);
            fmt = FMT_SH;
          end else begin
            imm = XLEN'($signed(instr[31:20]));
            fmt = FMT_I;
          end
        end
        OP_IMM32: begin
          if (XLEN == 64) begin
            // Word shifts only ever carry a 5-bit shift amount.
            if (is_shift(funct3)) begin
              imm = XLEN'(instr[24:20]);
              fmt = FMT_SH;
            end else begin
              imm = XLEN'($signed(instr[31:20]));
              fmt = FMT_I;
            end
          end else begin
            illegal = 1'b1;
          end
        end
        LOAD, JALR, SYSTEM: begin
          imm = XLEN'($signed(instr[31:20]));
          fmt = FMT_I;
        end
        STORE: begin
          imm = XLEN'($signed({instr[31:25], instr[11:7]}));
          fmt = FMT_S;
        end
        BRANCH: begin
          imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
          fmt = FMT_B;
        end
        LUI, AUIPC: begin
          imm = XLEN'($signed({instr[31:12], 12'b0}));
          fmt = FMT_U;
        end
        JAL: begin
          imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
          fmt = FMT_J;
        end
        OP: begin
          fmt = FMT_R;
        end
        OP32: begin
          illegal = (XLEN != 64);
        end
        default: begin
          illegal = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Decode-stage immediate generator behind a valid/ready handshake with a 2-entry skid buffer.
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] imm_o,
  output fmt_e            fmt_o,
  output logic            illegal_o,
  output logic [XLEN-1:0] target_o
);

  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_illegal;
  entry_t          new_entry;
  entry_t          out_q;
  entry_t          skid_q;
  logic            out_v;
  logic            skid_v;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr   (instr_i),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  // Package the incoming instruction with its decoded fields and PC-relative target.
  always_comb begin
    new_entry         = '0;
    new_entry.instr   = instr_i;
    new_entry.pc      = XLEN_MAX'(pc_i);
    new_entry.imm     = XLEN_MAX'(dec_imm);
    new_entry.fmt     = dec_fmt;
    new_entry.illegal = dec_illegal;
    new_entry.target  = XLEN_MAX'(pc_i + dec_imm);
  end

  // Output register plus skid register; the skid is only ever filled while the output stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      out_q  <= '0;
      skid_q <= '0;
    end else if (flush_i) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (!out_v || out_ready_i) begin
      if (skid_v) begin
        out_q  <= skid_q;
        out_v  <= 1'b1;
        skid_v <= 1'b0;
      end else if (in_valid_i) begin
        out_q <= new_entry;
        out_v <= 1'b1;
      end else begin
        out_v <= 1'b0;
      end
    end else if (in_valid_i && !skid_v) begin
      skid_q <= new_entry;
      skid_v <= 1'b1;
    end
  end

  assign in_ready_o  = !skid_v;
  assign out_valid_o = out_v;
  assign instr_o     = out_q.instr;
  assign pc_o        = out_q.pc[XLEN-1:0];
  assign imm_o       = out_q.imm[XLEN-1:0];
  assign fmt_o       = out_q.fmt;
  assign illegal_o   = out_q.illegal;
  assign target_o    = out_q.target[XLEN-1:0];

endmodule

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench for imm_gen_stage: driver pushes expected entries, monitor pops on output transfers.
module tb_imm_gen_stage;
  import imm_pkg::*;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    fmt_e        fmt;
    logic        illegal;
    logic [31:0] target;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] imm_o;
  fmt_e        fmt_o;
  logic        illegal_o;
  logic [31:0] target_o;

  logic        in_valid64 = 1'b0;
  logic        in_ready64;
  logic [31:0] instr64 = '0;
  logic [63:0] pc64 = '0;
  logic        out_valid64;
  logic        out_ready64 = 1'b1;
  logic        flush64 = 1'b0;
  logic [31:0] instr_o64;
  logic [63:0] pc_o64;
  logic [63:0] imm_o64;
  fmt_e        fmt_o64;
  logic        illegal_o64;
  logic [63:0] target_o64;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .instr_i(instr), .pc_i(pc),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .instr_o(instr_o), .pc_o(pc_o), .imm_o(imm_o),
    .fmt_o(fmt_o), .illegal_o(illegal_o), .target_o(target_o)
  );

  imm_gen_stage #(.XLEN(64)) dut64 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush64),
    .in_valid_i(in_valid64), .in_ready_o(in_ready64),
    .instr_i(instr64), .pc_i(pc64),
    .out_valid_o(out_valid64), .out_ready_i(out_ready64),
    .instr_o(instr_o64), .pc_o(pc_o64), .imm_o(imm_o64),
    .fmt_o(fmt_o64), .illegal_o(illegal_o64), .target_o(target_o64)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Offer one instruction until accepted; record the expected output at the accepting edge.
  task automatic send(input logic [31:0] i, input logic [31:0] p, input logic [31:0] im,
                      input fmt_e f, input logic ill, input logic [31:0] tg);
    exp_t e;
    bit   acc = 1'b0;
    e.instr = i; e.pc = p; e.imm = im; e.fmt = f; e.illegal = ill; e.target = tg;
    in_valid = 1'b1;
    instr    = i;
    pc       = p;
    for (int c = 0; c < 30 && !acc; c++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: instr %h never accepted", i);
    end
  endtask

  // Monitor: every output transfer must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_output: got instr %h expected none", instr_o);
        end else begin
          e = sb.pop_front();
          chk("out_instr",   64'(instr_o),   64'(e.instr));
          chk("out_pc",      64'(pc_o),      64'(e.pc));
          chk("out_imm",     64'(imm_o),     64'(e.imm));
          chk("out_fmt",     64'(fmt_o),     64'(e.fmt));
          chk("out_illegal", 64'(illegal_o), 64'(e.illegal));
          chk("out_target",  64'(target_o),  64'(e.target));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready",  64'(in_ready),  64'(1));
    chk("rst_imm",       64'(imm_o),     64'(0));
    chk("rst_fmt",       64'(fmt_o),     64'(FMT_R));
    chk("rst_target",    64'(target_o),  64'(0));
    #20;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Format decode with the output always ready.
    send(32'hFFF00093, 32'h1000, 32'hFFFFFFFF, FMT_I, 1'b0, 32'h00000FFF);
    send(32'h0020A423, 32'h1004, 32'h00000008, FMT_S, 1'b0, 32'h0000100C);
    send(32'h123450B7, 32'h1008, 32'h12345000, FMT_U, 1'b0, 32'h12346008);
    send(32'h008000EF, 32'h100C, 32'h00000008, FMT_J, 1'b0, 32'h00001014);
    send(32'h4030D093, 32'h2000, 32'h00000003, FMT_SH, 1'b0, 32'h00002003);
    send(32'h00000000, 32'h2004, 32'h00000000, FMT_R, 1'b1, 32'h00002004);
    send(32'h002081B3, 32'h2008, 32'h00000000, FMT_R, 1'b0, 32'h00002008);
    send(32'h03F09093, 32'h200C, 32'h0000001F, FMT_SH, 1'b0, 32'h0000202B);

    // Branch target visible one cycle after acceptance.
    send(32'hFE000EE3, 32'h0100, 32'hFFFFFFFC, FMT_B, 1'b0, 32'h000000FC);
    chk("br_latency_valid", 64'(out_valid), 64'(1));
    chk("br_target",        64'(target_o),  64'(32'h000000FC));
    @(posedge clk);
    #1;

    // Backpressure: A and B fill the buffer, C waits until the output drains.
    out_ready = 1'b0;
    fork
      begin
        send(32'h00100093, 32'h3000, 32'h00000001, FMT_I, 1'b0, 32'h00003001);
        send(32'h00200113, 32'h3004, 32'h00000002, FMT_I, 1'b0, 32'h00003006);
        chk("bp_in_ready_low", 64'(in_ready), 64'(0));
        send(32'h00300193, 32'h3008, 32'h00000003, FMT_I, 1'b0, 32'h0000300B);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("bp_drained", 64'(sb.size()), 64'(0));

    // Flush with both entries held and a new input offered in the same cycle.
    out_ready = 1'b0;
    send(32'h00400213, 32'h4000, 32'h00000004, FMT_I, 1'b0, 32'h00004004);
    send(32'h00500293, 32'h4004, 32'h00000005, FMT_I, 1'b0, 32'h00004009);
    chk("fl_skid_full", 64'(in_ready), 64'(0));
    flush    = 1'b1;
    in_valid = 1'b1;
    instr    = 32'h00600313;
    pc       = 32'h4008;
    @(negedge clk);
    sb.delete();
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", 64'(out_valid), 64'(0));
    chk("fl_in_ready",  64'(in_ready),  64'(1));
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("fl_input_lost", 64'(out_valid), 64'(0));

    // Asynchronous reset between edges with two entries held.
    out_ready = 1'b0;
    send(32'h00700393, 32'h5000, 32'h00000007, FMT_I, 1'b0, 32'h00005007);
    send(32'h00800413, 32'h5004, 32'h00000008, FMT_I, 1'b0, 32'h0000500C);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_out_valid", 64'(out_valid), 64'(0));
    chk("ar_in_ready",  64'(in_ready),  64'(1));
    chk("ar_instr",     64'(instr_o),   64'(0));
    chk("ar_fmt",       64'(fmt_o),     64'(FMT_R));
    sb.delete();
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'hFFC10493, 32'h6000, 32'hFFFFFFFC, FMT_I, 1'b0, 32'h00005FFC);
    chk("ar_latency_valid", 64'(out_valid), 64'(1));
    chk("ar_latency_instr", 64'(instr_o),   64'(32'hFFC10493));

    // XLEN=64 instance: 6-bit shift amount and sign-extended U immediate.
    in_valid64 = 1'b1;
    instr64    = 32'h03F09093;
    pc64       = 64'h0;
    @(posedge clk);
    #1;
    in_valid64 = 1'b1;
    instr64    = 32'h800000B7;
    pc64       = 64'h10;
    chk("x64_sh_valid", 64'(out_valid64), 64'(1));
    chk("x64_sh_imm",   imm_o64,          64'd63);
    chk("x64_sh_fmt",   64'(fmt_o64),     64'(FMT_SH));
    @(posedge clk);
    #1;
    in_valid64 = 1'b0;
    chk("x64_u_imm",    imm_o64,          64'hFFFFFFFF80000000);
    chk("x64_u_target", target_o64,       64'hFFFFFFFF80000010);
    chk("x64_u_fmt",    64'(fmt_o64),     64'(FMT_U));

    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
